// File: rtl/matmul_pkg.sv
// matmul_pkg: shared encodings for the matrix-multiply engine
// (FSM states, memory operation codes, header layout, mode bits).
package matmul_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR   = 4'd1,
    S_CHECK = 4'd2,
    S_RD_C  = 4'd3,
    S_RD_A  = 4'd4,
    S_RD_B  = 4'd5,
    S_MAC   = 4'd6,
    S_WR_C  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  // Header word offsets from BASE_ADDR
  localparam logic [2:0] HDR_WIDTH_A  = 3'd0;
  localparam logic [2:0] HDR_HEIGHT_A = 3'd1;
  localparam logic [2:0] HDR_WIDTH_B  = 3'd2;
  localparam logic [2:0] HDR_HEIGHT_B = 3'd3;
  localparam logic [2:0] HDR_MODE     = 3'd4;
  localparam int         HDR_WORDS    = 5;

  // Bits of the mode header word
  localparam int MODE_ACC_BIT = 0;
  localparam int MODE_TR_BIT  = 1;

endpackage

// File: rtl/matmul_engine_mac.sv
// matmul_engine_mac: accumulator register with extend/multiply/add,
// clear and preload, plus the write-back output stage.
// MATMUL_SATURATE_EN defined: write-back clamps to the DATA_W range;
// otherwise write-back is the low DATA_W bits of the accumulator.
module matmul_engine_mac #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int SIGNED = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_preload,
  input  logic [DATA_W-1:0] i_preload_val,
  input  logic              i_mac_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result
);

  localparam int PROD_W = 2 * DATA_W;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_pre_ext;

  if (SIGNED != 0) begin : g_signed
    logic signed [PROD_W-1:0] w_prod;
    assign w_prod     = PROD_W'($signed(i_a)) * PROD_W'($signed(i_b));
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_pre_ext  = ACC_W'($signed(i_preload_val));
  end else begin : g_unsigned
    logic [PROD_W-1:0] w_prod;
    assign w_prod     = PROD_W'(i_a) * PROD_W'(i_b);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_pre_ext  = ACC_W'(i_preload_val);
  end

  // Accumulator: clear per output element, optional preload from C, then MAC
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_preload) begin
      r_acc <= w_pre_ext;
    end else if (i_mac_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

`ifdef MATMUL_SATURATE_EN
  if (SIGNED != 0) begin : g_sat_signed
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    // Clamp the signed accumulator into the signed DATA_W range
    always_comb begin
      o_result = r_acc[DATA_W-1:0];
      if ($signed(r_acc) > $signed(SAT_MAX)) begin
        o_result = SAT_MAX[DATA_W-1:0];
      end else if ($signed(r_acc) < $signed(SAT_MIN)) begin
        o_result = SAT_MIN[DATA_W-1:0];
      end
    end
  end else begin : g_sat_unsigned
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({DATA_W{1'b1}});
    // Clamp the unsigned accumulator to the all-ones DATA_W value
    always_comb begin
      o_result = r_acc[DATA_W-1:0];
      if (r_acc > SAT_MAX) begin
        o_result = SAT_MAX[DATA_W-1:0];
      end
    end
  end
`else
  assign o_result = r_acc[DATA_W-1:0];
`endif

endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: fetches a 5-word header and operands over the single-port
// memory handshake, computes C = A*B (or C += A*B) and writes C back.
// Optional feature macro: MATMUL_SATURATE_EN (clamped write-back).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for enable; done/err cleared
// HDR     | five header reads (width_a, height_a, width_b, height_b, mode)
// CHECK   | compute base addresses, check zero dims and width_a==height_b
// RD_C    | accumulate mode: preload accumulator from C[i][j]
// RD_A    | read A[i][k]
// RD_B    | read B[k][j] (row-major or transposed layout)
// MAC     | one multiply-accumulate, then next k or write-back
// WR_C    | write C[i][j], then advance j / i or finish
// DONE    | done=1, busy=0; held until enable drops
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ACC_W     = 64,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                SIGNED    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              mem_opdone,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        mem_operation,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_A = BASE_ADDR + ADDR_W'(HDR_WORDS);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  state_t            r_state;
  logic [2:0]        r_hdr_idx;
  logic [ADDR_W-1:0] r_width_a, r_height_a, r_width_b, r_height_b;
  logic              r_mode_acc, r_mode_tr;
  logic [ADDR_W-1:0] r_base_b, r_base_c;
  logic [ADDR_W-1:0] r_i, r_j, r_k;
  logic [DATA_W-1:0] r_op_a, r_op_b;
  logic [1:0]        r_mem_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data_o;
  logic              r_busy, r_done, r_err;

  logic [ADDR_W-1:0] w_base_b_calc, w_base_c_calc;
  logic [ADDR_W-1:0] w_addr_a, w_addr_b, w_addr_c;
  logic [ADDR_W-1:0] w_req_addr;
  logic [1:0]        w_req_op;
  logic [ADDR_W-1:0] w_i_next, w_j_next, w_k_next;
  logic              w_xfer_done;
  logic              w_any_zero;
  logic              w_mac_clear, w_mac_preload, w_mac_en;
  logic [DATA_W-1:0] w_c_out;

  assign w_base_b_calc = BASE_A + r_height_a * r_width_a;
  assign w_base_c_calc = w_base_b_calc + r_height_b * r_width_b;

  assign w_addr_a = BASE_A + r_i * r_width_a + r_k;
  assign w_addr_b = r_mode_tr ? (r_base_b + r_j * r_height_b + r_k)
                              : (r_base_b + r_k * r_width_b + r_j);
  assign w_addr_c = r_base_c + r_i * r_width_b + r_j;

  assign w_i_next = r_i + ONE;
  assign w_j_next = r_j + ONE;
  assign w_k_next = r_k + ONE;

  assign w_any_zero = (r_width_a == '0) || (r_height_a == '0) ||
                      (r_width_b == '0) || (r_height_b == '0);

  // A completion only counts while a transaction is actually outstanding
  assign w_xfer_done = (r_mem_op != MEM_NONE) && mem_opdone;

  assign w_mac_clear   = (r_state == S_CHECK) || ((r_state == S_WR_C) && w_xfer_done);
  assign w_mac_preload = (r_state == S_RD_C) && w_xfer_done;
  assign w_mac_en      = (r_state == S_MAC);

  // Address and operation of the transaction belonging to the current state
  always_comb begin
    w_req_addr = '0;
    w_req_op   = MEM_READ;
    case (r_state)
      S_HDR:  w_req_addr = BASE_ADDR + ADDR_W'(r_hdr_idx);
      S_RD_C: w_req_addr = w_addr_c;
      S_RD_A: w_req_addr = w_addr_a;
      S_RD_B: w_req_addr = w_addr_b;
      S_WR_C: begin
        w_req_addr = w_addr_c;
        w_req_op   = MEM_WRITE;
      end
      default: w_req_op = MEM_NONE;
    endcase
  end

  matmul_engine_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_clear       (w_mac_clear),
    .i_preload     (w_mac_preload),
    .i_preload_val (data_i),
    .i_mac_en      (w_mac_en),
    .i_a           (r_op_a),
    .i_b           (r_op_b),
    .o_result      (w_c_out)
  );

  // Control FSM; every transaction state issues from an idle bus, which
  // guarantees a mem_operation=00 cycle between consecutive transactions
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_hdr_idx  <= '0;
      r_width_a  <= '0;
      r_height_a <= '0;
      r_width_b  <= '0;
      r_height_b <= '0;
      r_mode_acc <= 1'b0;
      r_mode_tr  <= 1'b0;
      r_base_b   <= '0;
      r_base_c   <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_mem_op   <= MEM_NONE;
      r_addr     <= '0;
      r_data_o   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (enable) begin
            r_state   <= S_HDR;
            r_busy    <= 1'b1;
            r_hdr_idx <= '0;
          end
        end

        S_HDR, S_RD_C, S_RD_A, S_RD_B, S_WR_C: begin
          if (r_mem_op == MEM_NONE) begin
            r_mem_op <= w_req_op;
            r_addr   <= w_req_addr;
            r_data_o <= (w_req_op == MEM_WRITE) ? w_c_out : '0;
          end else if (mem_opdone) begin
            r_mem_op <= MEM_NONE;
            r_data_o <= '0;
            case (r_state)
              S_HDR: begin
                case (r_hdr_idx)
                  HDR_WIDTH_A:  r_width_a  <= ADDR_W'(data_i);
                  HDR_HEIGHT_A: r_height_a <= ADDR_W'(data_i);
                  HDR_WIDTH_B:  r_width_b  <= ADDR_W'(data_i);
                  HDR_HEIGHT_B: r_height_b <= ADDR_W'(data_i);
                  HDR_MODE: begin
                    r_mode_acc <= data_i[MODE_ACC_BIT];
                    r_mode_tr  <= data_i[MODE_TR_BIT];
                  end
                  default: ;
                endcase
                if (r_hdr_idx == HDR_MODE) begin
                  r_state <= S_CHECK;
                end else begin
                  r_hdr_idx <= r_hdr_idx + 3'd1;
                end
              end
              S_RD_C: r_state <= S_RD_A;
              S_RD_A: begin
                r_op_a  <= data_i;
                r_state <= S_RD_B;
              end
              S_RD_B: begin
                r_op_b  <= data_i;
                r_state <= S_MAC;
              end
              default: begin
                r_k <= '0;
                if (w_j_next < r_width_b) begin
                  r_j     <= w_j_next;
                  r_state <= r_mode_acc ? S_RD_C : S_RD_A;
                end else if (w_i_next < r_height_a) begin
                  r_j     <= '0;
                  r_i     <= w_i_next;
                  r_state <= r_mode_acc ? S_RD_C : S_RD_A;
                end else begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end
            endcase
          end
        end

        S_CHECK: begin
          r_base_b <= w_base_b_calc;
          r_base_c <= w_base_c_calc;
          r_i      <= '0;
          r_j      <= '0;
          r_k      <= '0;
          if (w_any_zero || (r_width_a != r_height_b)) begin
            // Zero-sized jobs are legal no-ops; only a true mismatch flags err
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= !w_any_zero;
          end else begin
            r_state <= r_mode_acc ? S_RD_C : S_RD_A;
          end
        end

        S_MAC: begin
          if (w_k_next < r_width_a) begin
            r_k     <= w_k_next;
            r_state <= S_RD_A;
          end else begin
            r_state <= S_WR_C;
          end
        end

        S_DONE: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_mem_op <= MEM_NONE;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign data_o        = r_data_o;
  assign addr_o        = r_addr;
  assign mem_operation = r_mem_op;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule
